id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register and load-use hazard controller for the 5-stage RISC-V core. It captures decoded operands and controls from ID and presents ex_rs1/ex_rs2/ex_DataA/ex_DataB and controls to EX, where the forwarding unit and operand muxes consume them. It detects load-use hazards, stalls PC and IF/ID, and inserts bubbles into EX. It flushes on a taken branch resolved in EX.

Parameters:
XLEN, 32, datapath width.
LOAD_USE_BUBBLES, 1, bubbles per load-use hazard; legal range 1..3.
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
id_valid  input  1  ID holds a real instruction.
id_pc  input  XLEN  PC of the ID instruction.
id_rs1  input  5  source register 1.
id_rs2  input  5  source register 2.
id_rd  input  5  destination register.
id_uses_rs1  input  1  instruction reads rs1.
id_uses_rs2  input  1  instruction reads rs2.
id_DataA  input  XLEN  regfile read data A.
id_DataB  input  XLEN  regfile read data B.
id_imm  input  XLEN  immediate.
id_RegWEn  input  1  writes rd.
id_MemRW  input  1  store.
id_MemRd  input  1  load.
id_ALUSel  input  4  ALU operation.
ex_flush  input  1  taken branch or jump resolved in EX this cycle.
ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_DataA, ex_DataB, ex_imm, ex_RegWEn, ex_MemRW, ex_MemRd, ex_ALUSel  output  (widths as id_*)  registered EX-stage copies.
stall  output  1  hold PC and IF/ID this cycle (combinational).
stall_cnt  output  CNT_W  count of stalled cycles.

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous and active-low. While rst_n=0, all ex_* = 0, stall_cnt = 0, and state = RUN. stall = 0 while in reset.
- Bubble means every ex_* register is written to 0, including ex_valid, ex_RegWEn, ex_MemRW and ex_MemRd.
- load_use = id_valid & ex_valid & ex_MemRd & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- A reference to x0 never produces a hazard. A source register with id_uses_*=0 is ignored.
- FSM states are RUN and BUBBLE, with a 2-bit counter rem.
- RUN, no flush, no load_use: stall=0. On the edge, all id_* are captured into ex_* (1-cycle latency).
- RUN with load_use: stall=1 and a bubble is inserted on the edge.
  - If LOAD_USE_BUBBLES>1: go to BUBBLE with rem = LOAD_USE_BUBBLES-1.
  - Otherwise: stay in RUN. The next cycle re-evaluates with the bubble in EX, so load_use=0 and the ID instruction is captured.
- BUBBLE: stall=1 regardless of load_use, and a bubble is inserted each edge. rem decrements. When rem==1 on the edge, go to RUN.
- Total stall cycles per hazard = LOAD_USE_BUBBLES exactly.
- ex_flush has highest priority in any state:
  - stall=0 that cycle.
  - A bubble is inserted on the edge.
  - State goes to RUN and rem goes to 0.
  - The IF/ID flush is handled outside this block.
- stall_cnt increments on every edge where stall=1. It saturates at all-ones and is cleared only by reset.
- Reset asserted mid-stall returns to RUN immediately. No pending stall survives reset.

Test Plan:
1. Reset: drive a valid instruction, then pull rst_n low mid-cycle -> all ex_* = 0 and stall = 0 immediately, without waiting for clk. After release, stall_cnt = 0.
2. Back-to-back ALU ops (add x3,x1,x2 then sub x4,x3,x1) -> each appears on ex_* one cycle after ID, stall never asserts, and ex_rs1 = 3 for sub.
3. LOAD_USE_BUBBLES=1: lw x5 then add x6,x5,x1 -> stall=1 for exactly 1 cycle. EX sees ex_valid=0 for one cycle, then the add with ex_rs1 = 5. stall_cnt = 1.
4. No-hazard cases, each -> stall = 0 and stall_cnt unchanged:
   - lw x0 then add x6,x0,x1.
   - lw x5 then an instruction with id_rs2 = 5 but id_uses_rs2 = 0.
5. LOAD_USE_BUBBLES=2: lw x7 then use of x7 -> stall held for 2 consecutive cycles, 2 bubbles in EX, then the consumer is captured. stall_cnt = 2.
6. ex_flush=1 in the same cycle as load_use, and separately during BUBBLE -> stall = 0 that cycle, ex_valid = 0 next cycle, and the FSM is back in RUN.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts LOAD_USE_BUBBLES bubbles per hazard and flushes on EX redirect.
module id_ex_stage #(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_DataA,
  input  logic [XLEN-1:0]  id_DataB,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_RegWEn,
  input  logic             id_MemRW,
  input  logic             id_MemRd,
  input  logic [3:0]       id_ALUSel,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_DataA,
  output logic [XLEN-1:0]  ex_DataB,
  output logic [XLEN-1:0]  ex_imm,
  output logic             ex_RegWEn,
  output logic             ex_MemRW,
  output logic             ex_MemRd,
  output logic [3:0]       ex_ALUSel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] data_a;
    logic [XLEN-1:0] data_b;
    logic [XLEN-1:0] imm;
    logic            reg_wen;
    logic            mem_rw;
    logic            mem_rd;
    logic [3:0]      alu_sel;
  } id_ex_t;

  typedef enum logic {
    RUN,
    BUBBLE
  } state_e;

  localparam logic [1:0] REM_INIT = 2'(LOAD_USE_BUBBLES - 1);
  localparam bit MULTI = (LOAD_USE_BUBBLES > 1);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  id_ex_t           ex_q, ex_d, id_bus;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_rs1, hit_rs2;
  logic             load_use;
  logic             bubble;
  logic             stall_o;

  always_comb begin
    id_bus         = '0;
    id_bus.valid   = id_valid;
    id_bus.pc      = id_pc;
    id_bus.rs1     = id_rs1;
    id_bus.rs2     = id_rs2;
    id_bus.rd      = id_rd;
    id_bus.data_a  = id_DataA;
    id_bus.data_b  = id_DataB;
    id_bus.imm     = id_imm;
    id_bus.reg_wen = id_RegWEn;
    id_bus.mem_rw  = id_MemRW;
    id_bus.mem_rd  = id_MemRd;
    id_bus.alu_sel = id_ALUSel;
  end

  // x0 as a load target never creates a dependency
  always_comb begin
    hit_rs1  = id_uses_rs1 && (id_rs1 == ex_q.rd);
    hit_rs2  = id_uses_rs2 && (id_rs2 == ex_q.rd);
    load_use = id_valid && ex_q.valid && ex_q.mem_rd &&
               (ex_q.rd != 5'd0) && (hit_rs1 || hit_rs2);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall_o = 1'b0;
    bubble  = 1'b0;
    if (ex_flush) begin
      bubble  = 1'b1;
      state_d = RUN;
      rem_d   = 2'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            stall_o = 1'b1;
            bubble  = 1'b1;
            if (MULTI) begin
              state_d = BUBBLE;
              rem_d   = REM_INIT;
            end
          end
        end
        BUBBLE: begin
          stall_o = 1'b1;
          bubble  = 1'b1;
          rem_d   = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    ex_d  = bubble ? '0 : id_bus;
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
      ex_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ex_q    <= ex_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid  = ex_q.valid;
  assign ex_pc     = ex_q.pc;
  assign ex_rs1    = ex_q.rs1;
  assign ex_rs2    = ex_q.rs2;
  assign ex_rd     = ex_q.rd;
  assign ex_DataA  = ex_q.data_a;
  assign ex_DataB  = ex_q.data_b;
  assign ex_imm    = ex_q.imm;
  assign ex_RegWEn = ex_q.reg_wen;
  assign ex_MemRW  = ex_q.mem_rw;
  assign ex_MemRd  = ex_q.mem_rd;
  assign ex_ALUSel = ex_q.alu_sel;
  assign stall     = stall_o;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage with one, then two bubbles per hazard.
// Instance 0 uses LOAD_USE_BUBBLES=1, instance 1 uses 2.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_DataA, id_DataB, id_imm;
  logic        id_RegWEn, id_MemRW, id_MemRd;
  logic [3:0]  id_ALUSel;
  logic        ex_flush;

  logic        o_valid [2];
  logic [31:0] o_pc    [2];
  logic [4:0]  o_rs1   [2];
  logic [4:0]  o_rs2   [2];
  logic [4:0]  o_rd    [2];
  logic [31:0] o_da    [2];
  logic [31:0] o_db    [2];
  logic [31:0] o_imm   [2];
  logic        o_rwe   [2];
  logic        o_mrw   [2];
  logic        o_mrd   [2];
  logic [3:0]  o_alu   [2];
  logic        o_stall [2];
  logic [15:0] o_cnt   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_ex_stage #(
      .XLEN(32),
      .LOAD_USE_BUBBLES(g + 1),
      .CNT_W(16)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_rd      (id_rd),
      .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2),
      .id_DataA   (id_DataA),
      .id_DataB   (id_DataB),
      .id_imm     (id_imm),
      .id_RegWEn  (id_RegWEn),
      .id_MemRW   (id_MemRW),
      .id_MemRd   (id_MemRd),
      .id_ALUSel  (id_ALUSel),
      .ex_flush   (ex_flush),
      .ex_valid   (o_valid[g]),
      .ex_pc      (o_pc[g]),
      .ex_rs1     (o_rs1[g]),
      .ex_rs2     (o_rs2[g]),
      .ex_rd      (o_rd[g]),
      .ex_DataA   (o_da[g]),
      .ex_DataB   (o_db[g]),
      .ex_imm     (o_imm[g]),
      .ex_RegWEn  (o_rwe[g]),
      .ex_MemRW   (o_mrw[g]),
      .ex_MemRd   (o_mrd[g]),
      .ex_ALUSel  (o_alu[g]),
      .stall      (o_stall[g]),
      .stall_cnt  (o_cnt[g])
    );
  end

  typedef struct {
    int          dut;
    logic        st;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        mr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Expectations describe what is visible in the cycle the vector is driven
  task automatic step(input int d, input logic v, input logic [31:0] pc,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic u1, input logic u2,
                      input logic mr, input logic fl,
                      input logic est, input logic ev,
                      input logic [31:0] epc, input logic [4:0] ers1,
                      input logic [4:0] erd, input logic emr,
                      input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid    = v;
    id_pc       = pc;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_DataA    = v ? pc + 32'h1000 : 32'h0;
    id_DataB    = pc + 32'h2;
    id_imm      = 32'h4;
    id_RegWEn   = v;
    id_MemRW    = 1'b0;
    id_MemRd    = mr;
    id_ALUSel   = 4'h0;
    ex_flush    = fl;
    e = '{dut: d, st: est, v: ev, pc: epc, rs1: ers1, rd: erd, mr: emr,
          cnt: ecnt};
    sb.push_back(e);
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_pc       = '0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rd       = '0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    id_DataA    = '0;
    id_DataB    = '0;
    id_imm      = '0;
    id_RegWEn   = 1'b0;
    id_MemRW    = 1'b0;
    id_MemRd    = 1'b0;
    id_ALUSel   = '0;
    ex_flush    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t r;
      int   d;
      r = sb.pop_front();
      d = r.dut;
      chk($sformatf("d%0d_stall", d), 32'(o_stall[d]), 32'(r.st));
      chk($sformatf("d%0d_ex_valid", d), 32'(o_valid[d]), 32'(r.v));
      chk($sformatf("d%0d_ex_pc", d), o_pc[d], r.pc);
      chk($sformatf("d%0d_ex_rs1", d), 32'(o_rs1[d]), 32'(r.rs1));
      chk($sformatf("d%0d_ex_rd", d), 32'(o_rd[d]), 32'(r.rd));
      chk($sformatf("d%0d_ex_MemRd", d), 32'(o_mrd[d]), 32'(r.mr));
      chk($sformatf("d%0d_ex_RegWEn", d), 32'(o_rwe[d]), 32'(r.v));
      chk($sformatf("d%0d_ex_DataA", d), o_da[d],
          r.v ? r.pc + 32'h1000 : 32'h0);
      chk($sformatf("d%0d_stall_cnt", d), 32'(o_cnt[d]), 32'(r.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, queue=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("rst_cnt0", 32'(o_cnt[0]), 32'd0);

    // single-bubble instance
    step(0,1,'h100,1,2,3,1,1,0,0, 0,0,'h000,0,0,0,0);
    step(0,1,'h104,3,1,4,1,1,0,0, 0,1,'h100,1,3,0,0);
    step(0,1,'h108,1,0,5,1,0,1,0, 0,1,'h104,3,4,0,0);
    step(0,1,'h10c,5,1,6,1,1,0,0, 1,1,'h108,1,5,1,0);
    step(0,1,'h10c,5,1,6,1,1,0,0, 0,0,'h000,0,0,0,1);
    step(0,1,'h110,1,0,0,1,0,1,0, 0,1,'h10c,5,6,0,1);
    step(0,1,'h114,0,1,6,1,1,0,0, 0,1,'h110,1,0,1,1);
    step(0,1,'h118,1,0,5,1,0,1,0, 0,1,'h114,0,6,0,1);
    step(0,1,'h11c,2,5,7,1,0,0,0, 0,1,'h118,1,5,1,1);
    step(0,1,'h120,1,0,5,1,0,1,0, 0,1,'h11c,2,7,0,1);
    step(0,1,'h124,5,1,6,1,1,0,1, 0,1,'h120,1,5,1,1);
    step(0,0,'h000,0,0,0,0,0,0,0, 0,0,'h000,0,0,0,1);
    step(0,1,'h130,1,2,9,1,1,0,0, 0,0,'h000,0,0,0,1);

    // asynchronous reset in the middle of a cycle
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(o_valid[0]), 32'd1);
    chk("pre_rst_pc", o_pc[0], 32'h130);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_valid[0]), 32'd0);
    chk("async_rst_pc", o_pc[0], 32'h0);
    chk("async_rst_rs1", 32'(o_rs1[0]), 32'd0);
    chk("async_rst_stall", 32'(o_stall[0]), 32'd0);
    idle();
    @(posedge clk);
    #3 rst_n = 1'b1;
    chk("post_rst_cnt0", 32'(o_cnt[0]), 32'd0);
    chk("post_rst_cnt1", 32'(o_cnt[1]), 32'd0);

    // two-bubble instance, flushes on hazard and inside BUBBLE
    step(1,1,'h200,1,0,7,1,0,1,0, 0,0,'h000,0,0,0,0);
    step(1,1,'h204,7,2,8,1,1,0,0, 1,1,'h200,1,7,1,0);
    step(1,1,'h204,7,2,8,1,1,0,0, 1,0,'h000,0,0,0,1);
    step(1,1,'h204,7,2,8,1,1,0,0, 0,0,'h000,0,0,0,2);
    step(1,1,'h208,1,0,7,1,0,1,0, 0,1,'h204,7,8,0,2);
    step(1,1,'h20c,2,7,9,1,1,0,1, 0,1,'h208,1,7,1,2);
    step(1,1,'h20c,2,7,9,1,1,0,0, 0,0,'h000,0,0,0,2);
    step(1,1,'h210,1,0,7,1,0,1,0, 0,1,'h20c,2,9,0,2);
    step(1,1,'h214,7,0,10,1,0,0,0, 1,1,'h210,1,7,1,2);
    step(1,1,'h214,7,0,10,1,0,0,1, 0,0,'h000,0,0,0,3);
    step(1,1,'h214,7,0,10,1,0,0,0, 0,0,'h000,0,0,0,3);
    step(1,1,'h218,1,0,7,1,0,1,0, 0,1,'h214,7,10,0,3);
    step(1,1,'h21c,7,0,11,1,0,0,0, 1,1,'h218,1,7,1,3);

    // reset while parked in BUBBLE
    @(posedge clk);
    #1;
    chk("bubble_stall", 32'(o_stall[1]), 32'd1);
    chk("bubble_cnt", 32'(o_cnt[1]), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bubble_stall", 32'(o_stall[1]), 32'd0);
    chk("rst_bubble_valid", 32'(o_valid[1]), 32'd0);
    chk("rst_bubble_cnt", 32'(o_cnt[1]), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst_no_pending_stall", 32'(o_stall[1]), 32'd0);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_err);
    $finish;
  end

endmodule
